// File: rtl/bnn_layer_seq.sv
// Time-multiplexed binary neural network layer: one XNOR-popcount neuron per clock.
// Weights and thresholds arrive over a cascadable serial scan chain; inputs are written in banks.
module bnn_layer_seq #(
   parameter  int N_INPUTS   = 8,
   parameter  int N_OUTPUTS  = 8,
   parameter  int BANK_W     = 4,
   localparam int TH_W       = $clog2(N_INPUTS + 1),
   localparam int NB         = N_INPUTS + TH_W,
   localparam int PARAM_BITS = N_OUTPUTS * NB,
   localparam int NBANK      = N_INPUTS / BANK_W,
   localparam int BSEL_W     = (NBANK > 1) ? $clog2(NBANK) : 1,
   localparam int IDX_W      = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 setup,
   input  logic                 param_in,
   output logic                 param_out,
   input  logic [BANK_W-1:0]    x,
   input  logic [BSEL_W-1:0]    x_bank,
   input  logic                 x_we,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [N_OUTPUTS-1:0] y
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EVAL = 1'b1;

   logic [PARAM_BITS-1:0] r_p;
   logic [N_INPUTS-1:0]   r_x_reg;
   logic [N_INPUTS-1:0]   r_xs;
   logic [N_OUTPUTS-1:0]  r_work;
   logic [N_OUTPUTS-1:0]  r_y;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_busy;
   logic                  r_done;
   logic [0:0]            r_state;

   logic [N_INPUTS-1:0]   w_weight;
   logic [TH_W-1:0]       w_thresh;
   logic [N_INPUTS-1:0]   w_match;
   logic [TH_W-1:0]       w_pop;
   logic                  w_fire;
   logic                  w_last;
   logic [N_OUTPUTS-1:0]  w_work_next;

   // Shared neuron datapath: evaluates neuron r_idx against the snapshot r_xs.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_weight    = r_p[int'(r_idx) * NB +: N_INPUTS];
      w_thresh    = r_p[int'(r_idx) * NB + N_INPUTS +: TH_W];
      w_match     = ~(w_weight ^ r_xs);
      w_pop       = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         w_pop = w_pop + TH_W'(w_match[i]);
      end
      w_fire      = (w_pop >= w_thresh);
      w_last      = (r_idx == IDX_W'(N_OUTPUTS - 1));
      w_work_next = r_work;
      w_work_next[r_idx] = w_fire;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the parameter chain is plain flops, not a RAM, so it is reset along with everything else.
         r_p     <= '0;
         r_x_reg <= '0;
         r_xs    <= '0;
         r_work  <= '0;
         r_y     <= '0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_state <= ST_IDLE;
      end else begin
         r_done <= 1'b0;
         if (setup) begin
            // Shift mode dominates: aborts any run and discards inputs and results.
            r_p     <= {r_p[PARAM_BITS-2:0], param_in};
            r_x_reg <= '0;
            r_work  <= '0;
            r_y     <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
         end else begin
            if (x_we) begin
               for (int b = 0; b < NBANK; b++) begin
                  if (x_bank == BSEL_W'(b)) r_x_reg[b*BANK_W +: BANK_W] <= x;
               end
            end
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_xs    <= r_x_reg;
                     r_idx   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= ST_EVAL;
                  end
               end
               ST_EVAL: begin
                  r_work <= w_work_next;
                  if (w_last) begin
                     r_y     <= w_work_next;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign param_out = r_p[PARAM_BITS-1];
   assign busy      = r_busy;
   assign done      = r_done;
   assign y         = r_y;

endmodule
